neopixel_frame_ctrl: RTL

//  Frame scheduler/buffer for the neopixel serial driver. Owns a back buffer written pixel-by-pixel

---
 rtl/neopixel_frame_ctrl_if.sv | 25 ++
 rtl/neopixel_frame_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/neopixel_frame_ctrl_if.sv
// Pixel write port of the neopixel frame controller: valid/ready handshake carrying address and pixel word.
interface neopixel_frame_ctrl_if #(
    parameter int NUM_PIXELS = 24
);
    localparam int ADDR_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/neopixel_frame_ctrl.sv
// Frame scheduler with back/front pixel buffers feeding the neopixel serial driver.
// Optional per-byte brightness scaling is enabled by defining NEOPIXEL_BRIGHTNESS_EN.
module neopixel_frame_ctrl #(
    parameter int NUM_PIXELS  = 24,
    parameter int FRAME_TICKS = 266667,
    parameter int TX_TICKS    = 12520
) (
    input  logic                    clk_16MHz,
    input  logic                    rst_n,
    neopixel_frame_ctrl_if.slave    wr_if,
    input  logic                    commit_i,
    input  logic [7:0]              brightness_i,
    output logic                    start_tx_o,
    output logic [24*NUM_PIXELS-1:0] data_out_o,
    output logic                    frame_busy_o,
    output logic [15:0]             frame_count_o
);
    localparam int ADDR_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int TIMER_W = $clog2(FRAME_TICKS);
    localparam int TXC_W   = (TX_TICKS > 1) ? $clog2(TX_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, LATCH, TX} state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [ADDR_W-1:0]  index_q, index_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               pending_q, pending_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic [23:0]        back_q  [NUM_PIXELS];
    logic [23:0]        front_q [NUM_PIXELS];

    logic tick, last_px, tx_done, launch, wr_accept;

`ifdef NEOPIXEL_BRIGHTNESS_EN
    logic [7:0] bright_q, bright_d;

    // Each byte scaled by (brightness+1)/256 so 0xFF passes bytes through unchanged.
    function automatic logic [23:0] scale(input logic [23:0] px, input logic [7:0] br);
        logic [23:0] res;
        res = '0;
        for (int b = 0; b < 3; b++)
            res[8*b +: 8] = 8'((16'(px[8*b +: 8]) * (16'(br) + 16'd1)) >> 8);
        return res;
    endfunction
`else
    logic brightness_unused;
    assign brightness_unused = ^brightness_i;

    function automatic logic [23:0] scale(input logic [23:0] px);
        return px;
    endfunction
`endif

    assign tick      = (timer_q == TIMER_W'(FRAME_TICKS - 1));
    assign last_px   = (index_q == ADDR_W'(NUM_PIXELS - 1));
    assign tx_done   = (tx_cnt_q == TXC_W'(TX_TICKS - 1));
    // A commit arriving on the tick edge itself still launches this frame.
    assign launch    = (state_q == IDLE) && tick && (pending_q || commit_i);
    assign wr_accept = wr_if.wr_valid && wr_if.wr_ready && (32'(wr_if.wr_addr) < NUM_PIXELS);

    always_ff @(posedge clk_16MHz or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch)  state_d = LATCH;
            LATCH:   if (last_px) state_d = TX;
            TX:      if (tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_if.wr_ready = (state_q != LATCH);
        start_tx_o     = (state_q == TX);
        frame_busy_o   = (state_q != IDLE);
    end

    always_comb begin
        timer_d       = tick ? '0 : timer_q + TIMER_W'(1);
        index_d       = (state_q == LATCH && !last_px) ? index_q + ADDR_W'(1) : '0;
        tx_cnt_d      = (state_q == TX && !tx_done) ? tx_cnt_q + TXC_W'(1) : '0;
        pending_d     = launch ? 1'b0 : (pending_q | commit_i);
        frame_count_d = (state_q == TX && tx_done) ? frame_count_q + 16'd1 : frame_count_q;
`ifdef NEOPIXEL_BRIGHTNESS_EN
        bright_d      = launch ? brightness_i : bright_q;
`endif
    end

    always_ff @(posedge clk_16MHz or negedge rst_n) begin
        if (!rst_n) begin
            timer_q       <= '0;
            index_q       <= '0;
            tx_cnt_q      <= '0;
            pending_q     <= 1'b0;
            frame_count_q <= '0;
`ifdef NEOPIXEL_BRIGHTNESS_EN
            bright_q      <= '0;
`endif
        end else begin
            timer_q       <= timer_d;
            index_q       <= index_d;
            tx_cnt_q      <= tx_cnt_d;
            pending_q     <= pending_d;
            frame_count_q <= frame_count_d;
`ifdef NEOPIXEL_BRIGHTNESS_EN
            bright_q      <= bright_d;
`endif
        end
    end

    // Back buffer is written only outside LATCH, so the copy sees a stable frame.
    always_ff @(posedge clk_16MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
        end else begin
            if (wr_accept)
                back_q[wr_if.wr_addr] <= wr_if.wr_data;
            if (state_q == LATCH)
`ifdef NEOPIXEL_BRIGHTNESS_EN
                front_q[index_q] <= scale(back_q[index_q], bright_q);
`else
                front_q[index_q] <= scale(back_q[index_q]);
`endif
        end
    end

    always_comb begin
        data_out_o = '0;
        for (int i = 0; i < NUM_PIXELS; i++)
            data_out_o[24*(NUM_PIXELS-i)-1 -: 24] = front_q[i];
    end

    assign frame_count_o = frame_count_q;
endmodule
